jtframe_rom_arb: RTL and testbench
==================================

// Module: jtframe_rom_arb
// PURPOSE
// - Parametrised N-slot SDRAM read arbiter with a one-line (32-bit) cache per slot;
//   successor to the fixed 9-slot ROM controller used by game tops.
// - Sits between game ROM clients (CPU, sound, ADPCM, MCU, tile/object fetch) and the
//   frame SDRAM controller. Offsets are applied outside: slots present absolute word addresses.
// - Adds selectable fixed/round-robin priority, a per-slot vblank-only mask and a cache flush.
// PARAMETERS
// - SLOTS     9      number of client slots (1..16)
// - AW        22     SDRAM 16-bit word address width
// - RR        0      0 = fixed priority (lowest index wins); 1 = round-robin
// - VBL_ONLY  0      SLOTS-bit mask; a set bit lets that slot issue requests only while vblank=1
// PORTS
// - clk           in   1          system clock
// - rst_n         in   1          asynchronous reset, active low
// - vblank        in   1          vertical blank, gates VBL_ONLY slots
// - flush         in   1          pulse: invalidate all slot lines
// - slot_cs       in   SLOTS      per-slot request enable
// - slot_addr     in   SLOTS*AW   per-slot word address; slot i at [i*AW +: AW]
// - slot_dout     out  SLOTS*32   per-slot cached 32-bit line
// - slot_ok       out  SLOTS      slot_dout valid for the current slot_addr
// - downloading   in   1          ROM download active: arbiter idle, caches invalid
// - sdram_req     out  1          read request to SDRAM controller
// - sdram_ack     in   1          controller accepted the request
// - data_rdy      in   1          data_read valid (one cycle)
// - sdram_addr    out  AW         request address, always even (bit 0 = 0)
// - data_read     in   32         SDRAM read data
// - refresh_en    out  1          controller may refresh now
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE, all valid=0, tags=0, slot_dout=0, slot_ok=0,
//   sdram_req=0, sdram_addr=0, refresh_en=1, RR pointer=0.
// - Line: tag[i] = addr[AW-1:1]; one 32-bit SDRAM read fills both words of the line.
// - hit[i] = valid[i] & (tag[i]==slot_addr_i[AW-1:1]); slot_ok[i] = slot_cs[i] & hit[i]
//   (combinational; drops the same cycle cs or addr changes). slot_dout is registered.
// - miss[i] = slot_cs[i] & ~hit[i] & (~VBL_ONLY[i] | vblank).
// - FSM IDLE: if any miss and !downloading -> pick winner g, latch g, sdram_addr={addr_g[AW-1:1],1'b0},
//   sdram_req<=1, go WAIT_ACK. Request appears the cycle after the miss is visible.
// - Fixed priority: lowest-index missing slot. RR: first missing slot at index > last grant,
//   wrapping SLOTS-1 -> 0; pointer updates to g on grant.
// - WAIT_ACK: hold sdram_req and sdram_addr stable; on sdram_ack: sdram_req<=0, go WAIT_RDY.
//   If ack and data_rdy arrive together, treat as both (fill, go IDLE).
// - WAIT_RDY: on data_rdy: slot_dout[g]<=data_read, tag[g]<=latched address, valid[g]<=1, go IDLE.
//   slot_ok[g] rises the cycle after data_rdy if slot address is unchanged.
// - Address changed or cs dropped mid-fetch: fill still completes with the requested address;
//   a new miss is re-arbitrated from IDLE. No request is ever aborted after sdram_req rises.
// - data_rdy or sdram_ack in IDLE: ignored, no cache write.
// - flush: valid<=0 for all slots the next cycle; an in-flight fill completes and sets valid
//   (flush in the same cycle as data_rdy wins: line stays invalid).
// - downloading=1: valid<=0 every cycle, sdram_req<=0, FSM -> IDLE, slot_ok=0.
// - refresh_en = (state==IDLE) & ~|miss; 0 while WAIT_ACK/WAIT_RDY.
// - SLOTS=1: arbitration degenerates; RR pointer unused. Ties never exist (single grant).
// TESTING
// - Reset, slot0 cs addr 0x1000 -> sdram_req next cycle, sdram_addr=0x1000; ack, data_rdy with
//   0xDEADBEEF -> slot_ok[0]=1 next cycle, dout=0xDEADBEEF; addr 0x1001 -> ok stays 1, no new req.
// - RR=0, slots 2 and 5 miss together -> slot 2 served first, slot 5 second; RR=1 with continuous
//   misses on 0,2,5 -> grant order 0,2,5,0,2,5.
// - VBL_ONLY bit 3 set, slot3 misses with vblank=0 -> no req, refresh_en=1; vblank=1 -> req issued.
// - Slot1 addr changes 0x200->0x300 while in WAIT_RDY -> fill tag 0x100, ok stays 0, second request
//   at 0x300 issued after return to IDLE; then ok=1.
// - flush coincident with data_rdy -> slot_ok stays 0, re-request issued; downloading pulse during
//   WAIT_ACK -> sdram_req drops next cycle, all slot_ok=0 until refetch.
// - rst_n asserted mid WAIT_RDY -> outputs at reset values immediately; late data_rdy ignored.

Source files
------------

// File: rtl/jtframe_rom_arb_if.sv
// SDRAM read channel between the ROM arbiter (master) and the frame SDRAM controller (slave).
interface jtframe_rom_arb_if #(
  parameter int AW = 22
);
  logic          sdram_req;
  logic          sdram_ack;
  logic          data_rdy;
  logic [AW-1:0] sdram_addr;
  logic [31:0]   data_read;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy, data_read
  );
endinterface

// File: rtl/jtframe_rom_arb.sv
// N-slot SDRAM read arbiter: each slot keeps a one-line (two 16-bit words) cache and
// misses are served one at a time with fixed or round-robin priority.
module jtframe_rom_arb #(
  parameter int              SLOTS    = 9,
  parameter int              AW       = 22,
  parameter int              RR       = 0,
  parameter logic [SLOTS-1:0] VBL_ONLY = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vblank,
  input  logic                flush,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS*32-1:0] slot_dout,
  output logic [SLOTS-1:0]    slot_ok,
  output logic                refresh_en,
  jtframe_rom_arb_if.master   sdram
);

  localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t          state, state_nx;
  logic [SLOTS-1:0] valid, hit, miss;
  logic [AW-2:0]   tag [SLOTS];
  logic [GW-1:0]   gnt, rr_ptr, winner;
  logic            grant_en, fill_en;

  function automatic int wrap(input int v);
    return (v >= SLOTS) ? v - SLOTS : v;
  endfunction

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      hit[i]  = valid[i] && (tag[i] == slot_addr[i*AW+1 +: AW-1]);
      miss[i] = slot_cs[i] & ~hit[i] & (~VBL_ONLY[i] | vblank);
    end
  end

  assign slot_ok    = slot_cs & hit & {SLOTS{~downloading}};
  assign refresh_en = (state == IDLE) & ~|miss;

  // Loops run from the far end so the preferred candidate is the last one written.
  always_comb begin
    winner = '0;
    if (RR == 0) begin
      for (int i = SLOTS-1; i >= 0; i--)
        if (miss[i]) winner = GW'(i);
    end else begin
      for (int k = SLOTS; k >= 1; k--)
        if (miss[wrap(int'(rr_ptr) + k)]) winner = GW'(wrap(int'(rr_ptr) + k));
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    fill_en  = 1'b0;
    if (downloading) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (|miss) begin
          grant_en = 1'b1;
          state_nx = WAIT_ACK;
        end
        WAIT_ACK: if (sdram.sdram_ack) begin
          if (sdram.data_rdy) begin
            fill_en  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_RDY;
          end
        end
        WAIT_RDY: if (sdram.data_rdy) begin
          fill_en  = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: the tag/data lines are real registers with a defined reset value, not a RAM, so they are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid            <= '0;
      slot_dout        <= '0;
      sdram.sdram_req  <= 1'b0;
      sdram.sdram_addr <= '0;
      gnt              <= '0;
      rr_ptr           <= '0;
      for (int i = 0; i < SLOTS; i++) tag[i] <= '0;
    end else begin
      sdram.sdram_req <= (state_nx == WAIT_ACK);
      if (grant_en) begin
        gnt              <= winner;
        rr_ptr           <= winner;
        sdram.sdram_addr <= {slot_addr[int'(winner)*AW+1 +: AW-1], 1'b0};
      end
      // The fill always uses the address latched at grant, even if the slot moved on.
      if (fill_en) begin
        slot_dout[int'(gnt)*32 +: 32] <= sdram.data_read;
        tag[gnt]                      <= sdram.sdram_addr[AW-1:1];
      end
      if (downloading || flush) valid      <= '0;
      else if (fill_en)         valid[gnt] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: a fixed-priority instance (slot 3 vblank-only) and a round-robin
// instance, checked against a per-slot line-cache model and a priority-list arbitration model.
module tb_jtframe_rom_arb;

  localparam int SLOTS = 9;
  localparam int AW    = 22;
  localparam logic [SLOTS-1:0] VBL0 = 9'h008;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic                vblank [2];
  logic                flush  [2];
  logic                dl     [2];
  logic                ack    [2];
  logic                rdy    [2];
  logic [SLOTS-1:0]    cs     [2];
  logic [SLOTS*AW-1:0] addr   [2];
  logic [31:0]         rdata  [2];

  logic [SLOTS*32-1:0] dout0, dout1;
  logic [SLOTS-1:0]    ok0, ok1;
  logic                ref0, ref1;

  int n_pass = 0, n_fail = 0, n_total = 0;

  // Reference model: one cached line per slot, plus the round-robin pointer.
  logic          mvalid [2][SLOTS];
  logic [AW-2:0] mtag   [2][SLOTS];
  logic [31:0]   mdout  [2][SLOTS];
  int            mptr   [2];

  always #5 clk = ~clk;

  jtframe_rom_arb_if #(.AW(AW)) bus0 ();
  jtframe_rom_arb_if #(.AW(AW)) bus1 ();

  assign bus0.sdram_ack = ack[0];
  assign bus0.data_rdy  = rdy[0];
  assign bus0.data_read = rdata[0];
  assign bus1.sdram_ack = ack[1];
  assign bus1.data_rdy  = rdy[1];
  assign bus1.data_read = rdata[1];

  jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .RR(0), .VBL_ONLY(VBL0)) u_fix (
    .clk(clk), .rst_n(rst_n), .vblank(vblank[0]), .flush(flush[0]), .downloading(dl[0]),
    .slot_cs(cs[0]), .slot_addr(addr[0]), .slot_dout(dout0), .slot_ok(ok0),
    .refresh_en(ref0), .sdram(bus0)
  );

  jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .RR(1), .VBL_ONLY('0)) u_rr (
    .clk(clk), .rst_n(rst_n), .vblank(vblank[1]), .flush(flush[1]), .downloading(dl[1]),
    .slot_cs(cs[1]), .slot_addr(addr[1]), .slot_dout(dout1), .slot_ok(ok1),
    .refresh_en(ref1), .sdram(bus1)
  );

  function automatic logic get_req(input int d);
    return (d == 1) ? bus1.sdram_req : bus0.sdram_req;
  endfunction

  function automatic logic [AW-1:0] get_addr(input int d);
    return (d == 1) ? bus1.sdram_addr : bus0.sdram_addr;
  endfunction

  function automatic logic get_ok(input int d, input int i);
    return (d == 1) ? ok1[i] : ok0[i];
  endfunction

  function automatic logic [31:0] get_dout(input int d, input int i);
    return (d == 1) ? dout1[i*32 +: 32] : dout0[i*32 +: 32];
  endfunction

  function automatic logic get_ref(input int d);
    return (d == 1) ? ref1 : ref0;
  endfunction

  function automatic logic [31:0] mem_data(input logic [AW-2:0] line);
    return (32'(line) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [AW-2:0] line_of(input int d, input int i);
    return addr[d][i*AW+1 +: AW-1];
  endfunction

  function automatic bit m_hit(input int d, input int i);
    return mvalid[d][i] && (mtag[d][i] == line_of(d, i));
  endfunction

  function automatic bit m_miss(input int d, input int i);
    bit gated;
    gated = (d == 0) && VBL0[i] && !vblank[d];
    return cs[d][i] && !m_hit(d, i) && !gated;
  endfunction

  function automatic bit m_any_miss(input int d);
    for (int i = 0; i < SLOTS; i++) if (m_miss(d, i)) return 1'b1;
    return 1'b0;
  endfunction

  // Fixed: lowest missing index. Round-robin: first missing index after the last grant.
  function automatic int m_winner(input int d);
    if (d == 0) begin
      for (int i = 0; i < SLOTS; i++) if (m_miss(d, i)) return i;
    end else begin
      for (int k = 1; k <= SLOTS; k++) if (m_miss(d, (mptr[d] + k) % SLOTS)) return (mptr[d] + k) % SLOTS;
    end
    return -1;
  endfunction

  task automatic m_fill(input int d, input int g, input logic [AW-2:0] line,
                        input logic [31:0] data, input bit fl);
    mdout[d][g] = data;
    mtag[d][g]  = line;
    if (fl) for (int i = 0; i < SLOTS; i++) mvalid[d][i] = 1'b0;
    else    mvalid[d][g] = 1'b1;
    if (d == 1) mptr[d] = g;
  endtask

  task automatic m_clear(input int d);
    for (int i = 0; i < SLOTS; i++) mvalid[d][i] = 1'b0;
  endtask

  task automatic m_reset(input int d);
    for (int i = 0; i < SLOTS; i++) begin
      mvalid[d][i] = 1'b0;
      mtag[d][i]   = '0;
      mdout[d][i]  = '0;
    end
    mptr[d] = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int d, input int i, input logic [AW-1:0] a);
    addr[d][i*AW +: AW] = a;
  endtask

  task automatic check_slots(input int d);
    for (int i = 0; i < SLOTS; i++) begin
      check($sformatf("d%0d_ok%0d", d, i), 64'(get_ok(d, i)),
            64'(cs[d][i] && m_hit(d, i) && !dl[d]));
      check($sformatf("d%0d_dout%0d", d, i), 64'(get_dout(d, i)), 64'(mdout[d][i]));
    end
  endtask

  // Plays the SDRAM controller for one request with random ack/data latency.
  task automatic serve(input int d, input logic [AW-1:0] exp_a, input logic [31:0] data, input bit fl);
    int n, ad, rd;
    n = 0;
    while (!get_req(d) && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 64'(get_req(d)), 64'(1));
    check("req_addr", 64'(get_addr(d)), 64'(exp_a));
    if (!get_req(d)) return;
    ad = $urandom_range(0, 2);
    rd = $urandom_range(0, 2);
    repeat (ad) tick();
    check("req_hold", 64'({get_req(d), get_addr(d)}), 64'({1'b1, exp_a}));
    ack[d] = 1'b1;
    if (rd == 0) begin
      rdy[d]   = 1'b1;
      rdata[d] = data;
      flush[d] = fl;
    end
    tick();
    ack[d]   = 1'b0;
    rdy[d]   = 1'b0;
    flush[d] = 1'b0;
    if (rd > 0) begin
      repeat (rd - 1) tick();
      rdy[d]   = 1'b1;
      rdata[d] = data;
      flush[d] = fl;
      tick();
      rdy[d]   = 1'b0;
      flush[d] = 1'b0;
    end
    check("req_low_after_fill", 64'(get_req(d)), 64'(0));
  endtask

  task automatic serve_slot(input int d, input int g, input bit use_data,
                            input logic [31:0] data, input bit fl);
    logic [AW-2:0] line;
    logic [31:0]   dat;
    line = line_of(d, g);
    dat  = use_data ? data : mem_data(line);
    serve(d, {line, 1'b0}, dat, fl);
    m_fill(d, g, line, dat, fl);
  endtask

  task automatic drain(input int d);
    for (int n = 0; n < 40; n++) begin
      if (!m_any_miss(d)) break;
      serve_slot(d, m_winner(d), 1'b0, 32'h0, 1'b0);
    end
    tick();
    check("drain_req_idle", 64'(get_req(d)), 64'(0));
    check("drain_refresh", 64'(get_ref(d)), 64'(!m_any_miss(d)));
    check_slots(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_order [6];
    rr_order = '{0, 2, 5, 0, 2, 5};

    for (int d = 0; d < 2; d++) begin
      vblank[d] = 1'b0; flush[d] = 1'b0; dl[d] = 1'b0;
      ack[d] = 1'b0; rdy[d] = 1'b0; cs[d] = '0; addr[d] = '0; rdata[d] = '0;
      m_reset(d);
    end

    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_req", 64'(get_req(d)), 64'(0));
      check("rst_addr", 64'(get_addr(d)), 64'(0));
      check("rst_refresh", 64'(get_ref(d)), 64'(1));
      check_slots(d);
    end
    rst_n = 1'b1;
    tick();

    // Basic miss, fill, and same-line hit on the other word.
    cs[0][0] = 1'b1;
    set_addr(0, 0, 22'h1000);
    #1;
    check("t1_ok_before", 64'(ok0[0]), 64'(0));
    check("t1_refresh_miss", 64'(ref0), 64'(0));
    tick();
    check("t1_req_latency", 64'(get_req(0)), 64'(1));
    check("t1_req_addr", 64'(get_addr(0)), 64'(22'h1000));
    serve_slot(0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("t1_ok", 64'(ok0[0]), 64'(1));
    check("t1_dout", 64'(dout0[31:0]), 64'(32'hDEAD_BEEF));
    set_addr(0, 0, 22'h1001);
    #1;
    check("t1_ok_odd_word", 64'(ok0[0]), 64'(1));
    tick();
    tick();
    check("t1_no_new_req", 64'(get_req(0)), 64'(0));

    // Fixed priority: slots 2 and 5 miss together.
    set_addr(0, 2, 22'h2220);
    set_addr(0, 5, 22'h5550);
    cs[0][2] = 1'b1;
    cs[0][5] = 1'b1;
    serve_slot(0, 2, 1'b0, 32'h0, 1'b0);
    serve_slot(0, 5, 1'b0, 32'h0, 1'b0);
    drain(0);

    // Vblank-only slot is held off until vblank.
    set_addr(0, 3, 22'h3000);
    cs[0][3] = 1'b1;
    #1;
    check("t3_refresh_gated", 64'(ref0), 64'(1));
    repeat (3) tick();
    check("t3_no_req", 64'(get_req(0)), 64'(0));
    vblank[0] = 1'b1;
    #1;
    check("t3_refresh_vbl", 64'(ref0), 64'(0));
    tick();
    check("t3_req", 64'(get_req(0)), 64'(1));
    check("t3_req_addr", 64'(get_addr(0)), 64'(22'h3000));
    serve_slot(0, 3, 1'b0, 32'h0, 1'b0);
    drain(0);

    // Address moves while the fill is outstanding.
    set_addr(0, 1, 22'h0200);
    cs[0][1] = 1'b1;
    tick();
    check("t4_req", 64'(get_req(0)), 64'(1));
    check("t4_req_addr", 64'(get_addr(0)), 64'(22'h0200));
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    check("t4_req_dropped", 64'(get_req(0)), 64'(0));
    set_addr(0, 1, 22'h0300);
    tick();
    rdata[0] = 32'hCAFE_0001;
    rdy[0]   = 1'b1;
    tick();
    rdy[0] = 1'b0;
    m_fill(0, 1, 21'h100, 32'hCAFE_0001, 1'b0);
    check("t4_ok_stays0", 64'(ok0[1]), 64'(0));
    check("t4_dout_old_fill", 64'(get_dout(0, 1)), 64'(32'hCAFE_0001));
    serve_slot(0, 1, 1'b0, 32'h0, 1'b0);
    check("t4_ok_after_refetch", 64'(ok0[1]), 64'(1));
    drain(0);

    // Flush coincident with data_rdy keeps the line invalid and forces refetches.
    set_addr(0, 4, 22'h4000);
    cs[0][4] = 1'b1;
    serve_slot(0, 4, 1'b0, 32'h0, 1'b1);
    check("t5_flush_ok", 64'(ok0[4]), 64'(0));
    drain(0);

    // Download pulse while waiting for ack.
    set_addr(0, 6, 22'h6000);
    cs[0][6] = 1'b1;
    tick();
    check("t5_dl_req", 64'(get_req(0)), 64'(1));
    dl[0] = 1'b1;
    #1;
    check_slots(0);
    tick();
    dl[0] = 1'b0;
    check("t5_dl_req_drop", 64'(get_req(0)), 64'(0));
    m_clear(0);
    check_slots(0);
    drain(0);

    // Round robin: park the pointer on slot 5, then keep 0, 2 and 5 missing.
    set_addr(1, 5, 22'h5000);
    cs[1][5] = 1'b1;
    drain(1);
    set_addr(1, 0, 22'h0010);
    set_addr(1, 2, 22'h2010);
    set_addr(1, 5, 22'h5110);
    cs[1][0] = 1'b1;
    cs[1][2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve_slot(1, rr_order[k], 1'b0, 32'h0, 1'b0);
      set_addr(1, rr_order[k], AW'(rr_order[k] * 32'h1000 + (k + 2) * 32'h20));
    end
    drain(1);

    // Reset while a fill is outstanding; a late data_rdy must not write the cache.
    set_addr(0, 7, 22'h7000);
    cs[0][7] = 1'b1;
    tick();
    check("t7_req", 64'(get_req(0)), 64'(1));
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    rst_n = 1'b0;
    cs[0] = '0;
    cs[1] = '0;
    #1;
    m_reset(0);
    m_reset(1);
    check("t7_rst_req", 64'(get_req(0)), 64'(0));
    check("t7_rst_addr", 64'(get_addr(0)), 64'(0));
    check("t7_rst_refresh", 64'(ref0), 64'(1));
    check_slots(0);
    check_slots(1);
    tick();
    rst_n = 1'b1;
    tick();
    rdata[0] = 32'hBAD0_BAD0;
    rdy[0]   = 1'b1;
    ack[0]   = 1'b1;
    tick();
    rdy[0] = 1'b0;
    ack[0] = 1'b0;
    check("t7_idle_no_req", 64'(get_req(0)), 64'(0));
    cs[0][7] = 1'b1;
    #1;
    check_slots(0);
    drain(0);

    // Randomized traffic on both instances.
    for (int r = 0; r < 25; r++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 5) == 0) begin
          flush[d] = 1'b1;
          tick();
          flush[d] = 1'b0;
          m_clear(d);
        end
        cs[d] = SLOTS'($urandom);
        for (int i = 0; i < SLOTS; i++) begin
          case ($urandom_range(0, 3))
            2:       set_addr(d, i, addr[d][i*AW +: AW] ^ AW'(1));
            3:       set_addr(d, i, AW'($urandom_range(0, 127)));
            default: ;
          endcase
        end
        if (d == 0) vblank[0] = 1'($urandom_range(0, 1));
        #1;
        check_slots(d);
        drain(d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
